// File: rtl/rng_bank_pkg.sv
// Shared helpers for the stimulus bank: maximal-length LFSR tap masks,
// per-channel seed computation and the MISR fold chunk count.
package rng_bank_pkg;

  localparam int MAX_LFSR_WIDTH = 64;

  function automatic logic [63:0] tap_bit(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] taps2(input int a, input int b);
    return tap_bit(a) | tap_bit(b);
  endfunction

  function automatic logic [63:0] taps4(input int a, input int b, input int c, input int d);
    return taps2(a, b) | taps2(c, d);
  endfunction

  // Tap n of a classic tap table maps to mask bit n-1; width 8 yields 8'hB8.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] t;
    case (width)
      2:  t = taps2(2, 1);
      3:  t = taps2(3, 2);
      4:  t = taps2(4, 3);
      5:  t = taps2(5, 3);
      6:  t = taps2(6, 5);
      7:  t = taps2(7, 6);
      8:  t = taps4(8, 6, 5, 4);
      9:  t = taps2(9, 5);
      10: t = taps2(10, 7);
      11: t = taps2(11, 9);
      12: t = taps4(12, 6, 4, 1);
      13: t = taps4(13, 4, 3, 1);
      14: t = taps4(14, 5, 3, 1);
      15: t = taps2(15, 14);
      16: t = taps4(16, 15, 13, 4);
      17: t = taps2(17, 14);
      18: t = taps2(18, 11);
      19: t = taps4(19, 6, 2, 1);
      20: t = taps2(20, 17);
      21: t = taps2(21, 19);
      22: t = taps2(22, 21);
      23: t = taps2(23, 18);
      24: t = taps4(24, 23, 22, 17);
      25: t = taps2(25, 22);
      26: t = taps4(26, 6, 2, 1);
      27: t = taps4(27, 5, 2, 1);
      28: t = taps2(28, 25);
      29: t = taps2(29, 27);
      30: t = taps4(30, 6, 4, 1);
      31: t = taps2(31, 28);
      32: t = taps4(32, 22, 2, 1);
      33: t = taps2(33, 20);
      34: t = taps4(34, 27, 2, 1);
      35: t = taps2(35, 33);
      36: t = taps2(36, 25);
      37: t = taps4(37, 5, 4, 3) | taps2(2, 1);
      38: t = taps4(38, 6, 5, 1);
      39: t = taps2(39, 35);
      40: t = taps4(40, 38, 21, 19);
      41: t = taps2(41, 38);
      42: t = taps4(42, 41, 20, 19);
      43: t = taps4(43, 42, 38, 37);
      44: t = taps4(44, 43, 18, 17);
      45: t = taps4(45, 44, 42, 41);
      46: t = taps4(46, 45, 26, 25);
      47: t = taps2(47, 42);
      48: t = taps4(48, 47, 21, 20);
      49: t = taps2(49, 40);
      50: t = taps4(50, 49, 24, 23);
      51: t = taps4(51, 50, 36, 35);
      52: t = taps2(52, 49);
      53: t = taps4(53, 52, 38, 37);
      54: t = taps4(54, 53, 18, 17);
      55: t = taps2(55, 31);
      56: t = taps4(56, 55, 35, 34);
      57: t = taps2(57, 50);
      58: t = taps2(58, 39);
      59: t = taps4(59, 58, 38, 37);
      60: t = taps2(60, 59);
      61: t = taps4(61, 60, 46, 45);
      62: t = taps4(62, 61, 6, 5);
      63: t = taps2(63, 62);
      64: t = taps4(64, 63, 61, 60);
      default: t = '0;
    endcase
    return t;
  endfunction

  // A seed that wraps to zero would lock the LFSR, so it becomes 1.
  function automatic logic [63:0] ch_seed(input logic [63:0] base, input logic [63:0] stride,
                                          input int idx, input int width);
    logic [63:0] s;
    logic [63:0] m;
    m = (width >= MAX_LFSR_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    s = (base + 64'(idx) * stride) & m;
    return (s == '0) ? 64'd1 : s;
  endfunction

  function automatic int fold_chunks(input int obs_w, input int sig_w);
    return (obs_w + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/lfsr_channel.sv
// One Fibonacci shift-left LFSR channel with synchronous seed load and step enable.
module lfsr_channel
  import rng_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [63:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)      state_d = SEED;
    else if (step) state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/rng_stimulus_bank.sv
// Bank of seeded LFSR stimulus channels plus a windowed MISR that compacts
// observed DUT outputs into a published signature.
module rng_stimulus_bank
  import rng_bank_pkg::*;
#(
  parameter int          NUM_CH      = 6,
  parameter int          CH_WIDTH    = 64,
  parameter logic [63:0] SEED_BASE   = 64'd3,
  parameter logic [63:0] SEED_STRIDE = 64'd2,
  parameter int          OBS_WIDTH   = 64,
  parameter int          SIG_WIDTH   = 16,
  parameter int          SIG_WINDOW  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_en,
  input  logic [NUM_CH-1:0]            ch_hold,
  input  logic                         reseed,
  input  logic                         sig_clear,
  output logic [NUM_CH*CH_WIDTH-1:0]   stim_out,
  input  logic [OBS_WIDTH-1:0]         obs_in,
  output logic [SIG_WIDTH-1:0]         sig_out,
  output logic                         sig_valid
);

  localparam int                   CHUNKS    = fold_chunks(OBS_WIDTH, SIG_WIDTH);
  localparam int                   PAD_W     = CHUNKS * SIG_WIDTH;
  localparam int                   CNT_W     = $clog2(SIG_WINDOW);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SIG_WINDOW - 1);
  localparam logic [63:0]          MT_FULL   = lfsr_taps(SIG_WIDTH);
  localparam logic [SIG_WIDTH-1:0] MISR_TAPS = MT_FULL[SIG_WIDTH-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [63:0] SEED_I = ch_seed(SEED_BASE, SEED_STRIDE, i, CH_WIDTH);
    lfsr_channel #(
      .WIDTH (CH_WIDTH),
      .SEED  (SEED_I[CH_WIDTH-1:0])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .load  (reseed),
      .step  (step_en & ~ch_hold[i]),
      .state (stim_out[i*CH_WIDTH +: CH_WIDTH])
    );
  end

  logic [SIG_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic                 sig_valid_q, sig_valid_d;
  logic [PAD_W-1:0]     obs_pad;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] acc_step;

  always_comb begin
    obs_pad = PAD_W'(obs_in);
    fold    = '0;
    for (int c = 0; c < CHUNKS; c++) fold ^= obs_pad[c*SIG_WIDTH +: SIG_WIDTH];
    acc_step = {acc_q[SIG_WIDTH-2:0], ^(acc_q & MISR_TAPS)} ^ fold;
  end

  // Clear wins over both compaction and publication in the same cycle.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    sig_valid_d = 1'b0;
    if (sig_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (step_en) begin
      if (cnt_q == CNT_LAST) begin
        sig_d       = acc_step;
        sig_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  assign sig_out   = sig_q;
  assign sig_valid = sig_valid_q;

endmodule
